// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode/issue stage.
//   - opcode constants for the supported RV32IM subset
//   - immediate format enum and the 21-bit immediate formatter
//   - register-usage helpers (uses_rs1, uses_rs2, writes_rd)
//   - packed ID/EX bundle type
package decode_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;
   localparam int IMM_W  = 21;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_U,
      FMT_J,
      FMT_I,
      FMT_S,
      FMT_B
   } imm_fmt_t;

   typedef struct packed {
      logic [XLEN-1:0]   rs1_value;
      logic [XLEN-1:0]   rs2_value;
      logic [XLEN-1:0]   pc_value;
      logic [IMM_W-1:0]  imm;
      logic [4:0]        shamt;
      logic [2:0]        funct3;
      logic [6:0]        funct;
      logic [6:0]        opcode;
      logic [REG_AW-1:0] rd;
      logic              illegal;
   } idex_t;

   function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
      imm_fmt_t fmt;
      fmt = FMT_NONE;
      case (opc)
         OPC_LUI, OPC_AUIPC:                      fmt = FMT_U;
         OPC_JAL:                                 fmt = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OPIMM:           fmt = FMT_I;
         OPC_STORE:                               fmt = FMT_S;
         OPC_BRANCH:                              fmt = FMT_B;
         default:                                 fmt = FMT_NONE;
      endcase
      return fmt;
   endfunction

   // R-type (OP) carries no immediate, so it also maps to FMT_NONE -> 0.
   function automatic logic [IMM_W-1:0] fmt_imm(input logic [XLEN-1:0] instr,
                                                 input imm_fmt_t fmt);
      logic [IMM_W-1:0] imm;
      imm = '0;
      case (fmt)
         FMT_U: imm = {1'b0, instr[31:12]};
         FMT_J: imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_I: imm = {{9{instr[31]}}, instr[31:20]};
         FMT_S: imm = {{9{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: imm = {{8{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   function automatic logic uses_rs1(input logic [6:0] opc);
      logic r;
      r = 1'b0;
      case (opc)
         OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opc);
      logic r;
      r = 1'b0;
      case (opc)
         OPC_BRANCH, OPC_STORE, OPC_OP: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic writes_rd(input logic [6:0] opc);
      logic r;
      r = 1'b0;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_legal(input logic [6:0] opc);
      return uses_rs1(opc) || writes_rd(opc) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
   endfunction

endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: bundles the fetch handshake, the ID/EX operand bundle,
// the write-back port, the flush strobe and the scoreboard status.
//   slave  : the decode/issue stage
//   master : the surrounding pipeline (fetch, execute, write-back)
interface decode_issue_if;
   import decode_pkg::*;

   // fetch side
   logic              if_valid;
   logic              if_ready;
   logic [XLEN-1:0]   if_instr;
   logic [XLEN-1:0]   if_pc;
   // ID/EX bundle
   logic              id_valid;
   logic              ex_ready;
   logic [XLEN-1:0]   rs1_value;
   logic [XLEN-1:0]   rs2_value;
   logic [XLEN-1:0]   pc_value;
   logic [IMM_W-1:0]  imm;
   logic [4:0]        shamt;
   logic [2:0]        funct3;
   logic [6:0]        funct;
   logic [6:0]        opcode;
   logic [REG_AW-1:0] rd;
   logic              illegal;
   // write-back / redirect
   logic              wb_en;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              flush;
   // scoreboard status (one bit per architectural register)
   logic [NREGS-1:0]  busy;

   modport slave (
      input  if_valid, if_instr, if_pc, ex_ready, wb_en, wb_rd, wb_data, flush,
      output if_ready, id_valid, rs1_value, rs2_value, pc_value, imm, shamt,
             funct3, funct, opcode, rd, illegal, busy
   );

   modport master (
      output if_valid, if_instr, if_pc, ex_ready, wb_en, wb_rd, wb_data, flush,
      input  if_ready, id_valid, rs1_value, rs2_value, pc_value, imm, shamt,
             funct3, funct, opcode, rd, illegal, busy
   );

endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: 32 x 32 architectural register file.
//   clk, rst           : clock, async active-high reset (clears every register)
//   rs1_addr/rs1_data  : combinational read port 1
//   rs2_addr/rs2_data  : combinational read port 2
//   we/wr_addr/wr_data : synchronous write port
// A read that hits the register being written this cycle returns the new
// value. x0 reads as zero and ignores writes.
module decode_regfile
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_addr,
   output logic [XLEN-1:0]   rs1_data,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs2_data,
   input  logic              we,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [XLEN-1:0]   wr_data
);

   logic [XLEN-1:0] reg_file [NREGS];

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign reg_file[gi] = '0;
         end else begin : g_live
            logic [XLEN-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  q_reg <= '0;
               end else if (we && (wr_addr == REG_AW'(gi))) begin
                  q_reg <= wr_data;
               end
            end
            assign reg_file[gi] = q_reg;
         end
      end
   endgenerate

   assign rs1_data = (rs1_addr == '0)                  ? '0      :
                     (we && (wr_addr == rs1_addr))     ? wr_data :
                                                         reg_file[rs1_addr];
   assign rs2_data = (rs2_addr == '0)                  ? '0      :
                     (we && (wr_addr == rs2_addr))     ? wr_data :
                                                         reg_file[rs2_addr];

endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32IM decode/issue stage.
//   clk, rst : clock, async active-high reset
//   bus      : decode_issue_if.slave -- fetch handshake in, registered ID/EX
//              bundle out, write-back port, flush, scoreboard status
// Decodes the fetched word, reads operands (with write-back bypass), interlocks
// on RAW/WAW through a per-register busy scoreboard and holds one ID/EX bundle.
module decode_issue
   import decode_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   decode_issue_if.slave bus
);

   logic [XLEN-1:0]   instr;
   logic [6:0]        opc;
   logic [REG_AW-1:0] rs1_idx;
   logic [REG_AW-1:0] rs2_idx;
   logic [REG_AW-1:0] dest;
   logic              use_rs1;
   logic              use_rs2;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;

   logic [NREGS-1:0]  busy_reg;
   logic [NREGS-1:0]  busy_next;
   logic [NREGS-1:0]  busy_live;
   logic [NREGS-1:0]  wb_clr;
   logic [NREGS-1:0]  flush_clr;
   logic [NREGS-1:0]  acc_set;

   logic              rst_done_reg;
   logic              hazard;
   logic              ready;
   logic              accept;
   logic              id_valid_reg;
   logic              id_valid_next;
   idex_t             bundle_reg;
   idex_t             bundle_next;

   assign instr   = bus.if_instr;
   assign opc     = instr[6:0];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];
   assign use_rs1 = uses_rs1(opc);
   assign use_rs2 = uses_rs2(opc);
   // Illegal opcodes never write, so they carry rd=0 and touch no busy bit.
   assign dest    = writes_rd(opc) ? instr[11:7] : '0;

   decode_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (rs1_idx),
      .rs1_data (rs1_data),
      .rs2_addr (rs2_idx),
      .rs2_data (rs2_data),
      .we       (bus.wb_en),
      .wr_addr  (bus.wb_rd),
      .wr_data  (bus.wb_data)
   );

   // A busy bit being retired by this cycle's write-back no longer blocks:
   // the bypass path already delivers its value.
   assign wb_clr    = bus.wb_en ? (NREGS'(1) << bus.wb_rd) : '0;
   assign busy_live = busy_reg & ~wb_clr;

   assign hazard = (use_rs1 && busy_live[rs1_idx]) ||
                   (use_rs2 && busy_live[rs2_idx]) ||
                   ((dest != '0) && busy_live[dest]);

   // rst_done_reg keeps if_ready low until the first edge after reset.
   assign ready  = rst_done_reg && (!id_valid_reg || bus.ex_ready) && !hazard && !bus.flush;
   assign accept = bus.if_valid && ready;

   always_comb begin
      flush_clr = '0;
      acc_set   = '0;
      if (bus.flush && id_valid_reg) begin
         flush_clr = NREGS'(1) << bundle_reg.rd;
      end
      if (accept && (dest != '0)) begin
         acc_set = NREGS'(1) << dest;
      end
      // Set is applied after the clears so a same-index set wins; bit 0 stays 0.
      busy_next = ((busy_reg & ~wb_clr & ~flush_clr) | acc_set) & ~NREGS'(1);
   end

   always_comb begin
      id_valid_next = id_valid_reg;
      bundle_next   = bundle_reg;
      if (bus.flush) begin
         id_valid_next = 1'b0;
      end else if (accept) begin
         id_valid_next = 1'b1;
      end else if (bus.ex_ready) begin
         id_valid_next = 1'b0;
      end
      if (accept) begin
         bundle_next.rs1_value = rs1_data;
         bundle_next.rs2_value = rs2_data;
         bundle_next.pc_value  = bus.if_pc;
         bundle_next.imm       = fmt_imm(instr, imm_fmt_of(opc));
         bundle_next.shamt     = instr[24:20];
         bundle_next.funct3    = instr[14:12];
         bundle_next.funct     = instr[31:25];
         bundle_next.opcode    = opc;
         bundle_next.rd        = dest;
         bundle_next.illegal   = !is_legal(opc);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_done_reg <= 1'b0;
         id_valid_reg <= 1'b0;
         busy_reg     <= '0;
         bundle_reg   <= '0;
      end else begin
         rst_done_reg <= 1'b1;
         id_valid_reg <= id_valid_next;
         busy_reg     <= busy_next;
         bundle_reg   <= bundle_next;
      end
   end

   assign bus.if_ready  = ready;
   assign bus.id_valid  = id_valid_reg;
   assign bus.rs1_value = bundle_reg.rs1_value;
   assign bus.rs2_value = bundle_reg.rs2_value;
   assign bus.pc_value  = bundle_reg.pc_value;
   assign bus.imm       = bundle_reg.imm;
   assign bus.shamt     = bundle_reg.shamt;
   assign bus.funct3    = bundle_reg.funct3;
   assign bus.funct     = bundle_reg.funct;
   assign bus.opcode    = bundle_reg.opcode;
   assign bus.rd        = bundle_reg.rd;
   assign bus.illegal   = bundle_reg.illegal;
   assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed + randomized bench for decode_issue against a
// behavioural model (register array, busy set, single held bundle).
module tb_decode_issue;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_issue_if bus ();

   decode_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_regs [32];
   bit   [31:0] m_busy;
   bit          m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_rs1, m_rs2, m_pc;
   logic [20:0] m_imm;
   logic [4:0]  m_rd;
   bit          m_ill;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy  = '0;
      m_valid = 0;
      m_instr = '0;
      m_rs1   = '0;
      m_rs2   = '0;
      m_pc    = '0;
      m_imm   = '0;
      m_rd    = '0;
      m_ill   = 0;
   endtask

   // Decode from the ISA description: offsets computed as signed integers.
   task automatic ref_decode(input logic [31:0] ins, output bit u1, output bit u2,
                             output bit wr, output bit ill, output logic [20:0] im);
      int off;
      u1 = 0; u2 = 0; wr = 0; ill = 0; off = 0;
      case (ins[6:0])
         7'h37, 7'h17: begin wr = 1; off = int'(ins[31:12]); end
         7'h6F: begin
            wr = 1;
            off = (ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12)
                + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
         end
         7'h67, 7'h03, 7'h13: begin u1 = 1; wr = 1; off = $signed(ins) >>> 20; end
         7'h63: begin
            u1 = 1; u2 = 1;
            off = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         end
         7'h23: begin
            u1 = 1; u2 = 1;
            off = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
         end
         7'h33: begin u1 = 1; u2 = 1; wr = 1; off = 0; end
         default: begin ill = 1; off = 0; end
      endcase
      im = off[20:0];
   endtask

   function automatic bit blocked(input logic [4:0] idx, input bit wbe, input logic [4:0] wbrd);
      return m_busy[idx] && !(wbe && (wbrd == idx));
   endfunction

   // One clock: drive at negedge, check if_ready before the edge, advance the
   // model, check the registered outputs 1 time unit after the edge.
   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit exr, input bit wbe, input logic [4:0] wbrd,
                        input logic [31:0] wbd, input bit fl, output bit rdy);
      bit u1, u2, wr, ill, haz, exp_rdy, acc;
      logic [20:0] im;
      logic [4:0]  d, s1, s2;
      @(negedge clk);
      bus.if_valid = v;
      bus.if_instr = ins;
      bus.if_pc    = pc;
      bus.ex_ready = exr;
      bus.wb_en    = wbe;
      bus.wb_rd    = wbrd;
      bus.wb_data  = wbd;
      bus.flush    = fl;
      #1;
      ref_decode(ins, u1, u2, wr, ill, im);
      d  = wr ? ins[11:7] : 5'd0;
      s1 = ins[19:15];
      s2 = ins[24:20];
      haz = (u1 && blocked(s1, wbe, wbrd)) || (u2 && blocked(s2, wbe, wbrd)) ||
            ((d != 0) && blocked(d, wbe, wbrd));
      exp_rdy = (!m_valid || exr) && !haz && !fl;
      rdy = bus.if_ready;
      check_val("if_ready", {31'd0, rdy}, {31'd0, exp_rdy});
      acc = v && exp_rdy;
      // Register writes land first; an accepted read then sees the bypassed value.
      if (wbe && (wbrd != 0)) m_regs[wbrd] = wbd;
      if (wbe) m_busy[wbrd] = 0;
      if (fl && m_valid) m_busy[m_rd] = 0;
      if (acc && (d != 0)) m_busy[d] = 1;
      if (fl) m_valid = 0;
      else if (acc) begin
         m_valid = 1;
         m_instr = ins;
         m_rs1   = m_regs[s1];
         m_rs2   = m_regs[s2];
         m_pc    = pc;
         m_imm   = im;
         m_rd    = d;
         m_ill   = ill;
      end else if (exr) m_valid = 0;
      @(posedge clk);
      #1;
      check_val("id_valid",  {31'd0, bus.id_valid}, {31'd0, m_valid});
      check_val("busy",      bus.busy, m_busy);
      check_val("rs1_value", bus.rs1_value, m_rs1);
      check_val("rs2_value", bus.rs2_value, m_rs2);
      check_val("pc_value",  bus.pc_value, m_pc);
      check_val("imm",       {11'd0, bus.imm}, {11'd0, m_imm});
      check_val("shamt",     {27'd0, bus.shamt}, {27'd0, m_instr[24:20]});
      check_val("funct3",    {29'd0, bus.funct3}, {29'd0, m_instr[14:12]});
      check_val("funct",     {25'd0, bus.funct}, {25'd0, m_instr[31:25]});
      check_val("opcode",    {25'd0, bus.opcode}, {25'd0, m_instr[6:0]});
      check_val("rd",        {27'd0, bus.rd}, {27'd0, m_rd});
      check_val("illegal",   {31'd0, bus.illegal}, {31'd0, m_ill});
      $display("cyc v=%0d instr=%08h exr=%0d wb=%0d/%0d fl=%0d rdy=%0d id_valid=%0d busy=%08h",
               v, ins, exr, wbe, wbrd, fl, rdy, bus.id_valid, bus.busy);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [6:0]  opcs [10];
      logic [6:0]  bad [4];
      int k;
      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h13};
      bad  = '{7'h7F, 7'h0B, 7'h2F, 7'h73};
      ins = $urandom;
      k = $urandom_range(0, 10);
      if (k == 10) ins[6:0] = bad[$urandom_range(0, 3)];
      else         ins[6:0] = opcs[k];
      // Small register indices keep hazards frequent.
      if ($urandom_range(0, 3) != 0) begin
         ins[11:7]  = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
      end
      return ins;
   endfunction

   task automatic rand_cycles(input int n);
      bit rdy, wbe;
      logic [4:0] wbrd;
      int q[$];
      for (int c = 0; c < n; c++) begin
         q.delete();
         for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
         wbe = 0;
         wbrd = 5'($urandom_range(0, 31));
         if ((q.size() != 0) && ($urandom_range(0, 2) != 0)) begin
            wbe  = 1;
            wbrd = 5'(q[$urandom_range(0, q.size() - 1)]);
         end else if ($urandom_range(0, 7) == 0) begin
            wbe = 1;
         end
         drive($urandom_range(0, 4) != 0, rand_instr(), $urandom,
               $urandom_range(0, 3) != 0, wbe, wbrd, $urandom,
               $urandom_range(0, 15) == 0, rdy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rdy;
      rst = 1'b1;
      bus.if_valid = 0; bus.if_instr = '0; bus.if_pc = '0; bus.ex_ready = 0;
      bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0; bus.flush = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
      check_val("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
      check_val("rst_busy",     bus.busy, 32'd0);
      check_val("rst_imm",      {11'd0, bus.imm}, 32'd0);
      check_val("rst_illegal",  {31'd0, bus.illegal}, 32'd0);
      rst = 1'b0;

      // ADDI x1,x0,0x123
      drive(1, 32'h12300093, 32'h100, 1, 0, 0, 0, 0, rdy);
      check_val("addi_accept", {31'd0, rdy}, 32'd1);
      check_val("addi_valid",  {31'd0, bus.id_valid}, 32'd1);
      check_val("addi_opcode", {25'd0, bus.opcode}, 32'h13);
      check_val("addi_imm",    {11'd0, bus.imm}, 32'h123);
      check_val("addi_rd",     {27'd0, bus.rd}, 32'd1);
      check_val("addi_rs1",    bus.rs1_value, 32'd0);
      check_val("addi_busy1",  {31'd0, bus.busy[1]}, 32'd1);

      // ADD x2,x1,x1: stalls, then goes with write-back of x1 in the same cycle
      drive(1, 32'h00108133, 32'h104, 1, 0, 0, 0, 0, rdy);
      check_val("add_stall", {31'd0, rdy}, 32'd0);
      drive(1, 32'h00108133, 32'h104, 1, 1, 5'd1, 32'h10, 0, rdy);
      check_val("add_accept", {31'd0, rdy}, 32'd1);
      check_val("add_rs1",    bus.rs1_value, 32'h10);
      check_val("add_rs2",    bus.rs2_value, 32'h10);

      // BEQ x0,x0,-4
      drive(1, 32'hFE000EE3, 32'h108, 1, 0, 0, 0, 0, rdy);
      check_val("beq_imm",  {11'd0, bus.imm}, 32'h1FFFFC);
      check_val("beq_rd",   {27'd0, bus.rd}, 32'd0);
      check_val("beq_busy", bus.busy, 32'h4);

      // JAL x1,+0x800 ; LUI x5,0xABCDE
      drive(1, 32'h001000EF, 32'h10C, 1, 0, 0, 0, 0, rdy);
      check_val("jal_imm", {11'd0, bus.imm}, 32'h000800);
      drive(1, 32'hABCDE2B7, 32'h110, 1, 0, 0, 0, 0, rdy);
      check_val("lui_imm", {11'd0, bus.imm}, 32'h0ABCDE);

      // Hold with ex_ready low, then flush
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h12300193, 32'h114, 0, 0, 0, 0, 0, rdy);
         check_val("hold_ready",  {31'd0, rdy}, 32'd0);
         check_val("hold_opcode", {25'd0, bus.opcode}, 32'h37);
         check_val("hold_imm",    {11'd0, bus.imm}, 32'h0ABCDE);
         check_val("hold_pc",     bus.pc_value, 32'h110);
      end
      drive(1, 32'h12300193, 32'h114, 0, 0, 0, 0, 1, rdy);
      check_val("flush_ready", {31'd0, rdy}, 32'd0);
      check_val("flush_valid", {31'd0, bus.id_valid}, 32'd0);
      check_val("flush_busy5", {31'd0, bus.busy[5]}, 32'd0);

      // Illegal opcode 0x7F
      drive(1, 32'hFFFFFFFF, 32'h118, 1, 0, 0, 0, 0, rdy);
      check_val("ill_accept", {31'd0, rdy}, 32'd1);
      check_val("ill_flag",   {31'd0, bus.illegal}, 32'd1);
      check_val("ill_rd",     {27'd0, bus.rd}, 32'd0);
      check_val("ill_imm",    {11'd0, bus.imm}, 32'd0);

      rand_cycles(400);

      // Drain the scoreboard, then build a stall and reset in the middle of it
      for (int i = 1; i < 32; i++)
         if (m_busy[i]) drive(0, 32'h0, 32'h0, 1, 1, 5'(i), $urandom, 0, rdy);
      drive(0, 32'h0, 32'h0, 1, 0, 0, 0, 0, rdy);
      drive(1, 32'h12300393, 32'h200, 0, 0, 0, 0, 0, rdy);
      check_val("pre_rst_accept", {31'd0, rdy}, 32'd1);
      drive(1, 32'h00738433, 32'h204, 0, 0, 0, 0, 0, rdy);
      check_val("pre_rst_stall", {31'd0, rdy}, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_rst_valid", {31'd0, bus.id_valid}, 32'd0);
      check_val("async_rst_busy",  bus.busy, 32'd0);
      check_val("async_rst_ready", {31'd0, bus.if_ready}, 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rand_cycles(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
